pedestre_req: RTL and testbench
===============================

PEDESTRE_REQ -- requirements
Module: pedestre_req

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable cycles required to accept a button level change (>=1).
REQ-002 SHALL have parameter TICK_DIV, default 50000000, meaning clk cycles per tick_1hz pulse (>=2).
REQ-003 SHALL have parameter LOCKOUT_S, default 4, meaning ticks during which new presses are ignored after service (>=1).
REQ-004 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port botao  input  1  raw pedestrian push-button, asynchronous, may bounce.
REQ-007 SHALL have port atendido  input  1  synchronous pulse/level from the traffic controller: pedestrian phase entered.
REQ-008 SHALL have port tick_1hz  output  1  one-cycle pulse every TICK_DIV cycles, timebase for the controller.
REQ-009 SHALL have port botao_limpo  output  1  synchronized, debounced button level.
REQ-010 SHALL have port pedestre  output  1  latched pedestrian request, drives the controller's pedestre input.
REQ-011 SHALL have port pedidos  output  8  count of accepted requests, saturating.

Function
REQ-012 botao SHALL pass a 2-flip-flop synchronizer before any other use.
REQ-013 Debounce: counter SHALL increment each cycle synchronized input differs from botao_limpo, clear to 0 on any cycle it matches; botao_limpo toggles and counter clears when counter reaches DEBOUNCE_CYCLES-1 while still differing.
REQ-014 Latency: botao rising and held high SHALL produce botao_limpo high exactly DEBOUNCE_CYCLES+2 rising edges after first sampling edge.
REQ-015 A press event SHALL be a registered 0->1 edge of botao_limpo, one cycle wide, one cycle after botao_limpo rises; falling edges produce no event.
REQ-016 Tick: counter 0..TICK_DIV-1 free-running; tick_1hz SHALL be high exactly in cycles where counter == TICK_DIV-1; counter wraps to 0 next cycle.
REQ-017 FSM states SHALL be OCIOSO, PENDENTE, BLOQUEIO.
REQ-018 OCIOSO: press event -> PENDENTE next cycle and pedidos increments; atendido ignored.
REQ-019 PENDENTE: pedestre SHALL be 1 (registered, asserted the cycle the state is entered); further presses ignored, pedidos unchanged; atendido=1 -> BLOQUEIO.
REQ-020 Simultaneous press event and atendido in PENDENTE: SHALL go to BLOQUEIO, press discarded.
REQ-021 BLOQUEIO: pedestre=0; lockout counter cleared on entry, increments per tick_1hz; on the cycle the LOCKOUT_S-th tick is counted SHALL transition to OCIOSO; presses during BLOQUEIO discarded, not queued.
REQ-022 Press event in the same cycle as BLOQUEIO->OCIOSO transition SHALL be discarded.
REQ-023 pedidos SHALL saturate at 255; wrap-around forbidden.
REQ-024 pedestre SHALL be 1 only in PENDENTE; no other outputs depend combinationally on inputs.
REQ-025 Undefined state encodings SHALL recover to OCIOSO next cycle.

Reset
REQ-026 reset low SHALL immediately (asynchronously) force: state OCIOSO, pedestre=0, tick_1hz=0, botao_limpo=0, pedidos=0, synchronizer, debounce, tick and lockout counters 0.
REQ-027 Release of reset SHALL take effect on the next rising clk edge; first tick_1hz occurs TICK_DIV cycles after release.
REQ-028 reset asserted mid-PENDENTE or mid-BLOQUEIO SHALL discard the request/lockout; a button held through reset release is re-debounced from 0 and counts as a new press.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=10, LOCKOUT_S=3)
REQ-029 Clean press: botao 0->1 held -> botao_limpo=1 after 6 edges, pedestre=1 one cycle later, pedidos=1.
REQ-030 Bounce: botao toggles every 2 cycles for 20 cycles, then stays 0 -> botao_limpo stays 0, pedestre stays 0, pedidos=0.
REQ-031 Service and lockout: request pending, atendido pulse -> pedestre=0 next cycle; presses during the next 3 ticks ignored; press after return to OCIOSO -> pedestre=1, pedidos=2.
REQ-032 Collision: press event and atendido same cycle in PENDENTE -> BLOQUEIO, pedestre=0, pedidos unchanged.
REQ-033 Saturation: 260 accepted press/service cycles -> pedidos=255 constant.
REQ-034 Tick and reset: free-run 35 cycles -> tick_1hz pulses at cycles 10,20,30, each 1 cycle wide; reset low mid-PENDENTE -> pedestre=0, pedidos=0 immediately, without a clock edge.

Source files
------------

// File: rtl/pedestre_req.sv
// Pedestrian push-button front end: synchronizer, debouncer, 1 Hz timebase and a
// request latch with post-service lockout feeding the traffic-light controller.
module pedestre_req #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_DIV        = 50000000,
    parameter int LOCKOUT_S       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       botao,
    input  logic       atendido,
    output logic       tick_1hz,
    output logic       botao_limpo,
    output logic       pedestre,
    output logic [7:0] pedidos
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int LOCK_W = $clog2(LOCKOUT_S + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_S - 1);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        PENDENTE = 2'd1,
        BLOQUEIO = 2'd2
    } estado_t;

    logic              sync_0;
    logic              sync_1;
    logic [DB_W-1:0]   db_cnt;
    logic              limpo_q;
    logic              press_evt;
    logic [TICK_W-1:0] tick_cnt;
    logic [LOCK_W-1:0] lock_cnt;
    estado_t           estado;

    // NOTE: non-blocking assignments make each stage sample its pre-edge value,
    // so the two flops form a real two-stage chain instead of collapsing into one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_0 <= 1'b0;
            sync_1 <= 1'b0;
        end else begin
            sync_0 <= botao;
            sync_1 <= sync_0;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_cnt      <= '0;
            botao_limpo <= 1'b0;
            limpo_q     <= 1'b0;
        end else begin
            limpo_q <= botao_limpo;
            if (sync_1 != botao_limpo) begin
                if (db_cnt == DB_LAST) begin
                    botao_limpo <= sync_1;
                    db_cnt      <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Built only from registers, so the press event never sees botao combinationally.
    assign press_evt = botao_limpo & ~limpo_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    assign tick_1hz = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado   <= OCIOSO;
            pedestre <= 1'b0;
            lock_cnt <= '0;
            pedidos  <= 8'd0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (press_evt) begin
                        estado   <= PENDENTE;
                        pedestre <= 1'b1;
                        if (pedidos != 8'hFF) begin
                            pedidos <= pedidos + 8'd1;
                        end
                    end else begin
                        pedestre <= 1'b0;
                    end
                end
                PENDENTE: begin
                    // Service wins over a coincident press, which is simply dropped.
                    if (atendido) begin
                        estado   <= BLOQUEIO;
                        pedestre <= 1'b0;
                        lock_cnt <= '0;
                    end else begin
                        pedestre <= 1'b1;
                    end
                end
                BLOQUEIO: begin
                    pedestre <= 1'b0;
                    if (tick_1hz) begin
                        if (lock_cnt == LOCK_LAST) begin
                            estado   <= OCIOSO;
                            lock_cnt <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + LOCK_W'(1);
                        end
                    end
                end
                default: begin
                    estado   <= OCIOSO;
                    pedestre <= 1'b0;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pedestre_req.sv
// Self-checking bench for pedestre_req: directed vector table, corner-case sequences
// and a randomized run against a queue-based behavioural model.
module tb_pedestre_req;

    localparam int D = 4;
    localparam int T = 10;
    localparam int L = 3;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       botao    = 1'b0;
    logic       atendido = 1'b0;
    logic       tick_1hz;
    logic       botao_limpo;
    logic       pedestre;
    logic [7:0] pedidos;

    int n_cmp = 0;
    int n_bad = 0;

    pedestre_req #(
        .DEBOUNCE_CYCLES(D),
        .TICK_DIV       (T),
        .LOCKOUT_S      (L)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .botao      (botao),
        .atendido   (atendido),
        .tick_1hz   (tick_1hz),
        .botao_limpo(botao_limpo),
        .pedestre   (pedestre),
        .pedidos    (pedidos)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: button samples travel through a two-deep delay queue, the clean
    // level flips once the last D delayed samples all disagree with it, the tick is
    // edge count modulo T, and lockout counts remaining ticks down.
    logic m_dly[$];
    logic m_win[$];
    logic m_limpo;
    logic m_limpo_prev;
    int   m_mode;
    int   m_ticks_left;
    int   m_count;
    int   m_edges;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_dly.delete();
            m_dly.push_back(1'b0);
            m_dly.push_back(1'b0);
            m_win.delete();
            m_limpo      = 1'b0;
            m_limpo_prev = 1'b0;
            m_mode       = 0;
            m_ticks_left = 0;
            m_count      = 0;
            m_edges      = 0;
        end else begin
            logic s;
            logic tick_seen;
            logic press_seen;
            logic all_differ;
            tick_seen  = ((m_edges % T) == T - 1);
            press_seen = m_limpo && !m_limpo_prev;
            m_dly.push_back(botao);
            s = m_dly.pop_front();
            m_win.push_back(s);
            if (m_win.size() > D) void'(m_win.pop_front());
            all_differ = (m_win.size() == D);
            foreach (m_win[i]) if (m_win[i] == m_limpo) all_differ = 1'b0;
            m_limpo_prev = m_limpo;
            if (all_differ) m_limpo = !m_limpo;
            case (m_mode)
                0: if (press_seen) begin
                    m_mode = 1;
                    if (m_count < 255) m_count++;
                end
                1: if (atendido) begin
                    m_mode       = 2;
                    m_ticks_left = L;
                end
                default: if (tick_seen) begin
                    m_ticks_left--;
                    if (m_ticks_left == 0) m_mode = 0;
                end
            endcase
            m_edges++;
        end
    end

    task automatic run(input logic b, input logic a, input int n);
        botao    = b;
        atendido = a;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic b);
        @(negedge clk);
        reset    = 1'b0;
        botao    = b;
        atendido = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic       botao;
        logic       atendido;
        int         cycles;
        logic       e_limpo;
        logic       e_ped;
        logic [7:0] e_cnt;
        logic       e_tick;
        string      name;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int hold;

        // Edge numbers in the names count rising edges since reset release.
        vecs[0]  = '{1'b1, 1'b0, 5,  1'b0, 1'b0, 8'd0, 1'b0, "press e5 debouncing"};
        vecs[1]  = '{1'b1, 1'b0, 1,  1'b1, 1'b0, 8'd0, 1'b0, "press e6 limpo up"};
        vecs[2]  = '{1'b1, 1'b0, 1,  1'b1, 1'b1, 8'd1, 1'b0, "press e7 pedestre"};
        vecs[3]  = '{1'b0, 1'b0, 3,  1'b1, 1'b1, 8'd1, 1'b0, "release e10"};
        vecs[4]  = '{1'b0, 1'b0, 3,  1'b0, 1'b1, 8'd1, 1'b0, "release e13 limpo down"};
        vecs[5]  = '{1'b0, 1'b1, 1,  1'b0, 1'b0, 8'd1, 1'b0, "service e14"};
        vecs[6]  = '{1'b1, 1'b0, 10, 1'b1, 1'b0, 8'd1, 1'b0, "press in lockout e24"};
        vecs[7]  = '{1'b0, 1'b0, 9,  1'b0, 1'b0, 8'd1, 1'b0, "lockout idle e33"};
        vecs[8]  = '{1'b1, 1'b0, 6,  1'b1, 1'b0, 8'd1, 1'b1, "press edge e39"};
        vecs[9]  = '{1'b1, 1'b0, 1,  1'b1, 1'b0, 8'd1, 1'b0, "exit lockout e40"};
        vecs[10] = '{1'b1, 1'b0, 5,  1'b1, 1'b0, 8'd1, 1'b0, "held no event e45"};
        vecs[11] = '{1'b0, 1'b0, 10, 1'b0, 1'b0, 8'd1, 1'b0, "release e55"};
        vecs[12] = '{1'b1, 1'b0, 6,  1'b1, 1'b0, 8'd1, 1'b0, "press e61 limpo up"};
        vecs[13] = '{1'b1, 1'b0, 1,  1'b1, 1'b1, 8'd2, 1'b0, "press e62 accepted"};

        repeat (3) @(negedge clk);
        check1("reset limpo", botao_limpo, 1'b0);
        check1("reset pedestre", pedestre, 1'b0);
        check8("reset pedidos", pedidos, 8'd0);
        check1("reset tick", tick_1hz, 1'b0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            run(vecs[i].botao, vecs[i].atendido, vecs[i].cycles);
            check1({vecs[i].name, " limpo"}, botao_limpo, vecs[i].e_limpo);
            check1({vecs[i].name, " pedestre"}, pedestre, vecs[i].e_ped);
            check8({vecs[i].name, " pedidos"}, pedidos, vecs[i].e_cnt);
            check1({vecs[i].name, " tick"}, tick_1hz, vecs[i].e_tick);
        end

        // Collision: new press event lands on the same edge as atendido.
        run(1'b0, 1'b0, 10);
        check1("collision pre pedestre", pedestre, 1'b1);
        check1("collision pre limpo", botao_limpo, 1'b0);
        run(1'b1, 1'b0, 6);
        check1("collision limpo up", botao_limpo, 1'b1);
        run(1'b1, 1'b1, 1);
        check1("collision pedestre", pedestre, 1'b0);
        check8("collision pedidos", pedidos, 8'd2);
        run(1'b1, 1'b0, 40);
        check1("collision not queued", pedestre, 1'b0);
        check8("collision pedidos later", pedidos, 8'd2);

        // Asynchronous reset in PENDENTE, then a button held through release.
        run(1'b0, 1'b0, 8);
        run(1'b1, 1'b0, 8);
        check1("pre-reset pedestre", pedestre, 1'b1);
        check8("pre-reset pedidos", pedidos, 8'd3);
        #1 reset = 1'b0;
        #1;
        check1("async reset pedestre", pedestre, 1'b0);
        check8("async reset pedidos", pedidos, 8'd0);
        check1("async reset limpo", botao_limpo, 1'b0);
        check1("async reset tick", tick_1hz, 1'b0);
        do_reset(1'b1);
        run(1'b1, 1'b0, 6);
        check1("held thru reset limpo", botao_limpo, 1'b1);
        check1("held thru reset pedestre early", pedestre, 1'b0);
        run(1'b1, 1'b0, 1);
        check1("held thru reset pedestre", pedestre, 1'b1);
        check8("held thru reset pedidos", pedidos, 8'd1);

        // Tick phase after release, with a bouncing button that must never be accepted.
        do_reset(1'b0);
        for (int c = 1; c <= 35; c++) begin
            check1("tick phase", tick_1hz, (c % 10) == 0);
            check1("bounce limpo", botao_limpo, 1'b0);
            check1("bounce pedestre", pedestre, 1'b0);
            botao = (c <= 20) ? (((c - 1) / 2) % 2 == 0) : 1'b0;
            @(negedge clk);
        end
        check8("bounce pedidos", pedidos, 8'd0);

        // Saturation over 260 full press/service/lockout rounds.
        do_reset(1'b0);
        for (int i = 0; i < 260; i++) begin
            run(1'b1, 1'b0, 8);
            check1("sat pedestre", pedestre, 1'b1);
            check8("sat pedidos", pedidos, (i + 1 > 255) ? 8'd255 : 8'(i + 1));
            run(1'b1, 1'b1, 1);
            run(1'b0, 1'b0, 35);
        end
        check8("sat final pedidos", pedidos, 8'd255);

        // Randomized traffic against the model.
        do_reset(1'b0);
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            check1("rnd limpo", botao_limpo, m_limpo);
            check1("rnd pedestre", pedestre, m_mode == 1);
            check8("rnd pedidos", pedidos, 8'(m_count));
            check1("rnd tick", tick_1hz, (m_edges % T) == T - 1);
            if (hold == 0) begin
                botao = 1'($urandom_range(0, 1));
                hold  = $urandom_range(1, 12);
            end
            hold--;
            atendido = ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
